// File: rtl/featuremap_pkg.sv
// Shared constants and helpers for the multi-channel 3x3 convolution engine.
package featuremap_pkg;

  localparam int KERNEL_TAPS = 9;
  localparam int MAX_ACC_W   = 64;

  function automatic int acc_width(input int data_width, input int channels);
    return 2 * data_width + $clog2(KERNEL_TAPS * channels + 1);
  endfunction

  // Weights occupy c*9+k; the bias sits directly after the last kernel slice.
  function automatic int bias_addr(input int channels);
    return KERNEL_TAPS * channels;
  endfunction

  // Floor-rescale by frac_bits, then clamp to the signed data_width range.
  function automatic logic signed [MAX_ACC_W-1:0] sat_shift(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          data_width,
    input int                          frac_bits
  );
    logic signed [MAX_ACC_W-1:0] shifted;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    shifted = acc >>> frac_bits;
    hi      = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    if (shifted > hi) return hi;
    if (shifted < lo) return lo;
    return shifted;
  endfunction

endpackage

// File: rtl/featuremap_conv3x3_mc_window.sv
// Per-channel 3x3 sliding window: two row delay lines plus two registered columns;
// the newest column is taken combinationally so the taps include the incoming pixel.
module conv3x3_window
  import featuremap_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 208
) (
  input  logic                              Clk,
  input  logic                              shift,
  input  logic [DATA_WIDTH-1:0]             pix,
  output logic [KERNEL_TAPS*DATA_WIDTH-1:0] taps
);

  logic [DATA_WIDTH-1:0] line0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win   [3][2];

  always_ff @(posedge Clk) begin
    if (shift) begin
      line0[0] <= pix;
      line1[0] <= line0[IMG_WIDTH-1];
      for (int i = 1; i < IMG_WIDTH; i++) begin
        line0[i] <= line0[i-1];
        line1[i] <= line1[i-1];
      end
      for (int r = 0; r < 3; r++) win[r][0] <= win[r][1];
      win[0][1] <= line1[IMG_WIDTH-1];
      win[1][1] <= line0[IMG_WIDTH-1];
      win[2][1] <= pix;
    end
  end

  // Tap k (row-major, k=0 top-left) lives at [k*DATA_WIDTH +: DATA_WIDTH].
  assign taps = {pix,               win[2][1], win[2][0],
                 line0[IMG_WIDTH-1], win[1][1], win[1][0],
                 line1[IMG_WIDTH-1], win[0][1], win[0][0]};

endmodule

// File: rtl/featuremap_conv3x3_mc.sv
// Multi-channel 3x3 valid convolution with runtime weights, 3-cycle latency.
// Define FEATUREMAP_LEAKY_RELU_EN to apply a 1/8-slope leaky ReLU after saturation.
module featuremap_conv3x3_mc
  import featuremap_pkg::*;
#(
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_WIDTH  = 208,
  parameter int IMG_HEIGHT = 208
) (
  input  logic                                          Clk,
  input  logic                                          Rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                data_in,
  input  logic                                          valid_in,
  input  logic                                          wr_en,
  input  logic [$clog2(KERNEL_TAPS*CHANNELS+1)-1:0]     wr_addr,
  input  logic signed [DATA_WIDTH-1:0]                  wr_data,
  output logic signed [DATA_WIDTH-1:0]                  data_out,
  output logic                                          valid_out,
  output logic                                          frame_done,
  output logic                                          busy
);

  localparam int NTAPS  = KERNEL_TAPS * CHANNELS;
  localparam int ADDR_W = $clog2(NTAPS + 1);
  localparam int ACC_W  = acc_width(DATA_WIDTH, CHANNELS);
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] BIAS_A = ADDR_W'(bias_addr(CHANNELS));

`ifdef FEATUREMAP_LEAKY_RELU_EN
  function automatic logic signed [DATA_WIDTH-1:0] activate(input logic signed [DATA_WIDTH-1:0] x);
    return (x < 0) ? (x >>> 3) : x;
  endfunction
`else
  function automatic logic signed [DATA_WIDTH-1:0] activate(input logic signed [DATA_WIDTH-1:0] x);
    return x;
  endfunction
`endif

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             frame_active;
  logic             col_last, row_last, win_ok, wr_ok;

  assign col_last = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));
  assign win_ok   = valid_in && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col          <= '0;
      row          <= '0;
      frame_active <= 1'b0;
    end else if (valid_in) begin
      col          <= col_last ? '0 : col + COL_W'(1);
      if (col_last) row <= row_last ? '0 : row + ROW_W'(1);
      frame_active <= !(col_last && row_last);
    end
  end

  // Writes are only honoured with the engine fully idle, so a frame never sees mixed weights.
  logic signed [DATA_WIDTH-1:0] weight [NTAPS];
  logic signed [DATA_WIDTH-1:0] bias;

  assign wr_ok = wr_en && !busy && !valid_in && (wr_addr <= BIAS_A);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NTAPS; i++) weight[i] <= '0;
      bias <= '0;
    end else if (wr_ok) begin
      if (wr_addr == BIAS_A) bias <= wr_data;
      else                   weight[wr_addr] <= wr_data;
    end
  end

  logic [KERNEL_TAPS*DATA_WIDTH-1:0] win_taps [CHANNELS];
  logic signed [DATA_WIDTH-1:0]      tap      [NTAPS];

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    conv3x3_window #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMG_WIDTH  (IMG_WIDTH)
    ) u_win (
      .Clk   (Clk),
      .shift (valid_in),
      .pix   (data_in[ch*DATA_WIDTH +: DATA_WIDTH]),
      .taps  (win_taps[ch])
    );
    for (genvar k = 0; k < KERNEL_TAPS; k++) begin : g_tap
      assign tap[ch*KERNEL_TAPS+k] = win_taps[ch][k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // S1: one product per tap per channel
  logic signed [PW-1:0] prod_p0 [NTAPS];
  logic                 vld_p0, last_p0;

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NTAPS; i++) prod_p0[i] <= PW'(tap[i]) * PW'(weight[i]);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= win_ok;
      last_p0 <= col_last && row_last;
    end
  end

  // S2: full-width sum of all products plus bias aligned to the product scale
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_p1;
  logic                    vld_p1, last_p1;

  always_comb begin
    sum = ACC_W'(bias) <<< FRAC_BITS;
    for (int i = 0; i < NTAPS; i++) sum = sum + ACC_W'(prod_p0[i]);
  end

  always_ff @(posedge Clk) acc_p1 <= sum;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
    end
  end

  // S3: rescale, saturate, activation
  logic signed [MAX_ACC_W-1:0]  acc_ext;
  logic signed [DATA_WIDTH-1:0] sat_val;

  assign acc_ext = {{(MAX_ACC_W-ACC_W){acc_p1[ACC_W-1]}}, acc_p1};
  assign sat_val = DATA_WIDTH'(sat_shift(acc_ext, DATA_WIDTH, FRAC_BITS));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (vld_p1) data_out <= activate(sat_val);
      valid_out  <= vld_p1;
      frame_done <= vld_p1 && last_p1;
    end
  end

  assign busy = frame_active || vld_p0 || vld_p1 || valid_out;

endmodule
